// File: rtl/i2c_slv.sv
// i2c_slv: EEPROM-style I2C target running on the system clock.
//   Decodes a 7-bit device address, a 1- or 2-byte word address, then serves
//   byte/multi-byte writes and current-address, random and sequential reads
//   against an external synchronous byte memory.
// Ports:
//   clk, rst     system clock, synchronous active-high reset
//   addr_num     1 = 2-byte word address (high byte first), 0 = 1-byte
//   i2c_scl      bus clock from the master (asynchronous, oversampled)
//   i2c_sda      open-drain data line, driven only to 0 or z
//   mem_addr     word address pointer
//   mem_wr_en    one-cycle write strobe, with mem_wr_data
//   mem_rd_data  read byte, valid 1 clk after mem_addr changes
//   busy         high from address-matched START until STOP or abort
//   wr_done      1-clk pulse per byte written
//   rd_done      1-clk pulse per byte transmitted and acknowledged
module i2c_slv #(
  parameter logic [6:0]  DEVICE_ADDR = 7'b1010_000,
  parameter logic [25:0] CLK_FREQ    = 26'd50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        addr_num,
  input  logic        i2c_scl,
  inout  wire         i2c_sda,
  output logic [15:0] mem_addr,
  output logic        mem_wr_en,
  output logic [7:0]  mem_wr_data,
  input  logic [7:0]  mem_rd_data,
  output logic        busy,
  output logic        wr_done,
  output logic        rd_done
);

  // The bus must be oversampled at least 40x; reject nonsensical clocks.
  if (CLK_FREQ < 26'd40) begin : g_clk_check
    $error("i2c_slv: CLK_FREQ too low to oversample SCL");
  end

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, IGNORE, ACK_DEV, WADDR_H, ACK_AH, WADDR_L, ACK_AL,
    RX_DATA, ACK_RX, TX_BYTE, MACK
  } state_t;

  state_t     state;
  logic [2:0] scl_sr;     // [0],[1] synchroniser, [2] history
  logic [2:0] sda_sr;
  logic [2:0] bit_cnt;
  logic [7:0] shreg;
  logic       rw;
  logic       sda_oe;
  logic       skip_fall;  // ignore the SCL fall that completes a START

  logic scl, scl_h, sda, sda_h;
  logic scl_rise, scl_fall, start, stop;
  logic [7:0] rx_byte;

  assign scl      = scl_sr[1];
  assign scl_h    = scl_sr[2];
  assign sda      = sda_sr[1];
  assign sda_h    = sda_sr[2];
  assign scl_rise = scl & ~scl_h;
  assign scl_fall = ~scl & scl_h;
  assign start    = scl & scl_h & sda_h & ~sda;
  assign stop     = scl & scl_h & ~sda_h & sda;
  assign rx_byte  = {shreg[6:0], sda};

  assign i2c_sda = sda_oe ? 1'b0 : 1'bz;

  // Pointer advance; in 1-byte mode only the low byte counts, high stays 0.
  function automatic logic [15:0] next_addr(input logic [15:0] a, input logic two);
    next_addr = two ? (a + 16'd1) : {8'h00, a[7:0] + 8'd1};
  endfunction

  // Bus synchronisers; reset to the idle-high level so no false edges appear.
  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sr <= 3'b111;
      sda_sr <= 3'b111;
    end else begin
      scl_sr <= {scl_sr[1:0], i2c_scl};
      sda_sr <= {sda_sr[1:0], i2c_sda};
    end
  end

  // Protocol FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bit_cnt     <= 3'd0;
      shreg       <= 8'h00;
      rw          <= 1'b0;
      sda_oe      <= 1'b0;
      skip_fall   <= 1'b0;
      mem_addr    <= 16'h0000;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= 8'h00;
      busy        <= 1'b0;
      wr_done     <= 1'b0;
      rd_done     <= 1'b0;
    end else begin
      mem_wr_en <= 1'b0;
      wr_done   <= 1'b0;
      rd_done   <= 1'b0;
      // Pointer moves on the cycle after the strobe so the write sees the old value.
      if (mem_wr_en) mem_addr <= next_addr(mem_addr, addr_num);

      if (stop) begin
        state   <= IDLE;
        busy    <= 1'b0;
        sda_oe  <= 1'b0;
        bit_cnt <= 3'd0;
      end else if (start) begin
        state     <= DEV_ADDR;
        bit_cnt   <= 3'd0;
        sda_oe    <= 1'b0;
        skip_fall <= 1'b1;
      end else begin
        case (state)
          IDLE, IGNORE: sda_oe <= 1'b0;

          DEV_ADDR: begin
            if (scl_rise) shreg <= rx_byte;
            if (scl_fall) begin
              if (skip_fall) begin
                skip_fall <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                  if (shreg[7:1] == DEVICE_ADDR) begin
                    state  <= ACK_DEV;
                    busy   <= 1'b1;
                    rw     <= shreg[0];
                    sda_oe <= 1'b1;
                  end else begin
                    state <= IGNORE;
                    busy  <= 1'b0;
                  end
                end
              end
            end
          end

          WADDR_H, WADDR_L, RX_DATA: begin
            if (scl_rise) begin
              shreg <= rx_byte;
              if (state == RX_DATA && bit_cnt == 3'd7) begin
                mem_wr_en   <= 1'b1;
                wr_done     <= 1'b1;
                mem_wr_data <= rx_byte;
              end
            end
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b1;
                if (state == WADDR_H) begin
                  mem_addr[15:8] <= shreg;
                  state          <= ACK_AH;
                end else if (state == WADDR_L) begin
                  mem_addr <= addr_num ? {mem_addr[15:8], shreg} : {8'h00, shreg};
                  state    <= ACK_AL;
                end else begin
                  state <= ACK_RX;
                end
              end
            end
          end

          ACK_DEV: begin
            if (scl_fall) begin
              bit_cnt <= 3'd0;
              if (rw) begin
                state  <= TX_BYTE;
                shreg  <= mem_rd_data;
                sda_oe <= ~mem_rd_data[7];
              end else begin
                state  <= addr_num ? WADDR_H : WADDR_L;
                sda_oe <= 1'b0;
              end
            end
          end

          ACK_AH: begin
            if (scl_fall) begin
              state   <= WADDR_L;
              bit_cnt <= 3'd0;
              sda_oe  <= 1'b0;
            end
          end

          ACK_AL, ACK_RX: begin
            if (scl_fall) begin
              state   <= RX_DATA;
              bit_cnt <= 3'd0;
              sda_oe  <= 1'b0;
            end
          end

          TX_BYTE: begin
            if (scl_fall) begin
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state    <= MACK;
                sda_oe   <= 1'b0;
                mem_addr <= next_addr(mem_addr, addr_num);
              end else begin
                // shreg[7] is already on the wire; present the next bit.
                sda_oe <= ~shreg[6];
                shreg  <= {shreg[6:0], 1'b0};
              end
            end
          end

          MACK: begin
            if (scl_rise) begin
              if (!sda) begin
                rd_done <= 1'b1;
              end else begin
                state <= IGNORE;
                busy  <= 1'b0;
              end
            end
            if (scl_fall) begin
              state   <= TX_BYTE;
              bit_cnt <= 3'd0;
              shreg   <= mem_rd_data;
              sda_oe  <= ~mem_rd_data[7];
            end
          end

          default: begin
            state  <= IDLE;
            sda_oe <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
